// File: rtl/rps_match_controller_if.sv
// Play button, throw inputs and display-side outputs of the rock-paper-scissors
// match controller, bundled for the controller and its environment.
interface rps_match_controller_if;
   logic       playButton;
   logic [2:0] p1Throw;
   logic [2:0] p2Throw;
   logic [1:0] countdown;
   logic       reveal;
   logic [2:0] p1Latched;
   logic [2:0] p2Latched;
   logic [1:0] roundResult;
   logic [3:0] p1Score;
   logic [3:0] p2Score;
   logic       matchOver;
   logic [1:0] matchWinner;

   modport master (
      output playButton, p1Throw, p2Throw,
      input  countdown, reveal, p1Latched, p2Latched, roundResult,
             p1Score, p2Score, matchOver, matchWinner
   );

   modport slave (
      input  playButton, p1Throw, p2Throw,
      output countdown, reveal, p1Latched, p2Latched, roundResult,
             p1Score, p2Score, matchOver, matchWinner
   );
endinterface

// File: rtl/rps_match_controller.sv
// Best-of-N rock-paper-scissors sequencer: press detect, three-beat countdown,
// throw sampling and judging, timed reveal, score keeping and match end.
module rps_match_controller #(
   parameter int unsigned WINS_TO_MATCH = 3,
   parameter int unsigned BEAT_CYCLES   = 50000000,
   parameter int unsigned REVEAL_CYCLES = 100000000
) (
   input logic                   clk,
   input logic                   reset,
   rps_match_controller_if.slave bus
);
   localparam int unsigned BW = (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1;
   localparam int unsigned RW = (REVEAL_CYCLES > 1) ? $clog2(REVEAL_CYCLES) : 1;
   localparam logic [BW-1:0] BEAT_LAST   = BW'(BEAT_CYCLES - 1);
   localparam logic [RW-1:0] REVEAL_LAST = RW'(REVEAL_CYCLES - 1);
   localparam logic [3:0]    WIN_TGT     = 4'(WINS_TO_MATCH);

   typedef enum logic [1:0] {IDLE, COUNTDOWN, REVEAL, MATCH_OVER} state_t;

   state_t        state_q, state_d;
   logic          btn_q;
   logic          press_q, press_d;
   logic [1:0]    beat_q, beat_d;
   logic [BW-1:0] beat_cnt_q, beat_cnt_d;
   logic [RW-1:0] reveal_cnt_q, reveal_cnt_d;
   logic [2:0]    p1_lat_q, p1_lat_d, p2_lat_q, p2_lat_d;
   logic [1:0]    result_q, result_d;
   logic [3:0]    p1_score_q, p1_score_d, p2_score_q, p2_score_d;
   logic          match_over_q, match_over_d;
   logic [1:0]    winner_q, winner_d;
   logic [1:0]    round_result;

   function automatic logic [1:0] judge(input logic [2:0] a, input logic [2:0] b);
      logic a_ok, b_ok;
      a_ok = $onehot(a);
      b_ok = $onehot(b);
      if (a_ok && b_ok) begin
         if (a == b) return 2'b11;
         if ((a == 3'b001 && b == 3'b100) || (a == 3'b100 && b == 3'b010) ||
             (a == 3'b010 && b == 3'b001)) return 2'b01;
         return 2'b10;
      end
      if (a_ok) return 2'b01;
      if (b_ok) return 2'b10;
      return 2'b11;
   endfunction

   assign round_result = judge(bus.p1Throw, bus.p2Throw);

   // History resets to 1 so a button held across reset release is not a press.
   // Press pulses are registered only while waiting, so a rise during REVEAL
   // cannot leak into the following IDLE cycle.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q      <= IDLE;
         btn_q        <= 1'b1;
         press_q      <= 1'b0;
         beat_q       <= '0;
         beat_cnt_q   <= '0;
         reveal_cnt_q <= '0;
         p1_lat_q     <= '0;
         p2_lat_q     <= '0;
         result_q     <= '0;
         p1_score_q   <= '0;
         p2_score_q   <= '0;
         match_over_q <= 1'b0;
         winner_q     <= '0;
      end else begin
         state_q      <= state_d;
         btn_q        <= bus.playButton;
         press_q      <= press_d;
         beat_q       <= beat_d;
         beat_cnt_q   <= beat_cnt_d;
         reveal_cnt_q <= reveal_cnt_d;
         p1_lat_q     <= p1_lat_d;
         p2_lat_q     <= p2_lat_d;
         result_q     <= result_d;
         p1_score_q   <= p1_score_d;
         p2_score_q   <= p2_score_d;
         match_over_q <= match_over_d;
         winner_q     <= winner_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      press_d      = bus.playButton & ~btn_q & ((state_q == IDLE) | (state_q == MATCH_OVER));
      beat_d       = beat_q;
      beat_cnt_d   = beat_cnt_q;
      reveal_cnt_d = reveal_cnt_q;
      p1_lat_d     = p1_lat_q;
      p2_lat_d     = p2_lat_q;
      result_d     = result_q;
      p1_score_d   = p1_score_q;
      p2_score_d   = p2_score_q;
      match_over_d = match_over_q;
      winner_d     = winner_q;
      unique case (state_q)
         IDLE: begin
            if (press_q) begin
               state_d    = COUNTDOWN;
               beat_d     = 2'd3;
               beat_cnt_d = '0;
            end
         end
         COUNTDOWN: begin
            if (beat_cnt_q == BEAT_LAST) begin
               beat_cnt_d = '0;
               if (beat_q == 2'd1) begin
                  state_d      = REVEAL;
                  beat_d       = '0;
                  reveal_cnt_d = '0;
                  p1_lat_d     = bus.p1Throw;
                  p2_lat_d     = bus.p2Throw;
                  result_d     = round_result;
                  if (round_result == 2'b01 && p1_score_q != WIN_TGT)
                     p1_score_d = p1_score_q + 4'd1;
                  if (round_result == 2'b10 && p2_score_q != WIN_TGT)
                     p2_score_d = p2_score_q + 4'd1;
               end else begin
                  beat_d = beat_q - 2'd1;
               end
            end else begin
               beat_cnt_d = beat_cnt_q + BW'(1);
            end
         end
         REVEAL: begin
            if (reveal_cnt_q == REVEAL_LAST) begin
               if (p1_score_q == WIN_TGT || p2_score_q == WIN_TGT) begin
                  state_d      = MATCH_OVER;
                  match_over_d = 1'b1;
                  winner_d     = (p1_score_q == WIN_TGT) ? 2'b01 : 2'b10;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               reveal_cnt_d = reveal_cnt_q + RW'(1);
            end
         end
         MATCH_OVER: begin
            if (press_q) begin
               state_d      = IDLE;
               p1_lat_d     = '0;
               p2_lat_d     = '0;
               result_d     = '0;
               p1_score_d   = '0;
               p2_score_d   = '0;
               match_over_d = 1'b0;
               winner_d     = '0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.countdown   = beat_q;
   assign bus.reveal      = (state_q == REVEAL);
   assign bus.p1Latched   = p1_lat_q;
   assign bus.p2Latched   = p2_lat_q;
   assign bus.roundResult = result_q;
   assign bus.p1Score     = p1_score_q;
   assign bus.p2Score     = p2_score_q;
   assign bus.matchOver   = match_over_q;
   assign bus.matchWinner = winner_q;
endmodule
